// File: rtl/cmp4b_sort_ctrl_if.sv
// Load/control/read-back bundle for the in-place 4-bit sorter.
// The master side drives requests; the slave side is the sorter itself.
interface cmp4b_sort_ctrl_if #(
    parameter int N = 8
);
    localparam int AW = $clog2(N);

    logic          clr;
    logic          load_valid;
    logic [3:0]    load_data;
    logic          load_ready;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_data;
    logic [AW:0]   count;
    logic [7:0]    swap_count;

    modport master (
        output clr, load_valid, load_data, start, rd_addr,
        input  load_ready, busy, done, rd_data, count, swap_count
    );

    modport slave (
        input  clr, load_valid, load_data, start, rd_addr,
        output load_ready, busy, done, rd_data, count, swap_count
    );
endinterface

// File: rtl/cmp4b_sort_ctrl.sv
// Bubble sorter for up to N 4-bit entries, one cmp4b compare per cycle.
// Loads through a valid/ready port, pulses done when finished, and exposes the buffer.
module cmp4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);
    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

module cmp4b_sort_ctrl #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp4b_sort_ctrl_if.slave     bus
);
    localparam int AW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SORT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [3:0]    mem [N];
    logic [AW:0]   count;
    logic [AW-1:0] idx;
    logic [AW-1:0] last;
    logic          swapped;
    logic [7:0]    swap_count;

    logic          load_fire;
    logic [AW:0]   n_next;
    logic [AW-1:0] idx_nx;
    logic [3:0]    a_val;
    logic [3:0]    b_val;
    logic          gt;
    logic          eq;
    logic          lt;
    logic          cmp_unused;

    assign bus.load_ready = (state == S_IDLE) && (count < (AW+1)'(N));
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.count      = count;
    assign bus.swap_count = swap_count;
    assign bus.rd_data    = (32'(bus.rd_addr) < N) ? mem[bus.rd_addr] : 4'h0;

    // A load accepted alongside start is part of the sort scope.
    assign load_fire = bus.load_valid && bus.load_ready;
    assign n_next    = count + {{AW{1'b0}}, load_fire};

    assign idx_nx = idx + AW'(1);
    assign a_val  = mem[idx];
    assign b_val  = mem[idx_nx];

    cmp4b u_cmp (
        .a  (a_val),
        .b  (b_val),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    // Equal and less-than both leave the pair alone, which keeps the sort stable.
    assign cmp_unused = eq ^ lt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            idx        <= '0;
            last       <= '0;
            swapped    <= 1'b0;
            swap_count <= 8'd0;
            for (int k = 0; k < N; k++) begin
                mem[k] <= 4'h0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.clr) begin
                        count <= '0;
                    end else begin
                        if (load_fire) begin
                            mem[count[AW-1:0]] <= bus.load_data;
                            count              <= n_next;
                        end
                        if (bus.start) begin
                            idx        <= '0;
                            swapped    <= 1'b0;
                            swap_count <= 8'd0;
                            last       <= AW'(n_next - (AW+1)'(1));
                            state      <= (n_next >= (AW+1)'(2)) ? S_SORT : S_DONE;
                        end
                    end
                end

                S_SORT: begin
                    if (gt) begin
                        mem[idx]    <= b_val;
                        mem[idx_nx] <= a_val;
                        swapped     <= 1'b1;
                        if (swap_count != 8'hFF) begin
                            swap_count <= swap_count + 8'd1;
                        end
                    end
                    // The swap seen on the final compare of a pass still counts for that pass.
                    if (idx < last - AW'(1)) begin
                        idx <= idx_nx;
                    end else if (!(swapped || gt) || last == AW'(1)) begin
                        state <= S_DONE;
                    end else begin
                        last    <= last - AW'(1);
                        idx     <= '0;
                        swapped <= 1'b0;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
